// File: rtl/mul_dual_array_if.sv
// Operand/result bus for mul_dual_array (valid/ready on both sides).
// in_acc exists only when MUL_DUAL_ACC_EN is defined.
interface mul_dual_array_if #(
  parameter int N = 36,
  parameter int W = 8
);
  logic               in_valid;
  logic               in_ready;
  logic               in_signed;
`ifdef MUL_DUAL_ACC_EN
  logic               in_acc;
`endif
  logic [W*N-1:0]     in_1;
  logic [W*N-1:0]     in_2;
  logic [W*N-1:0]     in_3;
  logic               out_valid;
  logic               out_ready;
  logic [2*W*N-1:0]   out1;
  logic [2*W*N-1:0]   out2;

  modport master (
`ifdef MUL_DUAL_ACC_EN
    output in_acc,
`endif
    output in_valid, in_signed, in_1, in_2, in_3, out_ready,
    input  in_ready, out_valid, out1, out2
  );

  modport slave (
`ifdef MUL_DUAL_ACC_EN
    input  in_acc,
`endif
    input  in_valid, in_signed, in_1, in_2, in_3, out_ready,
    output in_ready, out_valid, out1, out2
  );
endinterface

// File: rtl/mul_dual_array.sv
// N-lane pipelined dual multiplier (A*C, B*C) with elastic valid/ready handshake.
// Optional MUL_DUAL_ACC_EN turns the output stage into per-lane accumulators.

module mul_dual_lane #(
  parameter int W   = 8,
  parameter int LAT = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           adv,
  input  logic           sgn,
`ifdef MUL_DUAL_ACC_EN
  input  logic           upd,
  input  logic           accf,
`endif
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [W-1:0]   c,
  output logic [2*W-1:0] p1,
  output logic [2*W-1:0] p2
);
  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
  } opnd_t;

  opnd_t          op;
  logic [2*W-1:0] ea, eb, ec;
  logic [2*W-1:0] m1, m2;
  logic [2*W-1:0] f1, f2;

  // Stage 0 holds operands when LAT>1; with LAT==1 the multiply feeds the output stage directly.
  generate
    if (LAT == 1) begin : g_op_comb
      assign op = {a, b, c};
    end else begin : g_op_reg
      always_ff @(posedge clk) begin
        if (adv) op <= {a, b, c};
      end
    end
  endgenerate

  // Extending to 2W and keeping the low 2W bits gives the exact product in both modes.
  assign ea = {{W{sgn & op.a[W-1]}}, op.a};
  assign eb = {{W{sgn & op.b[W-1]}}, op.b};
  assign ec = {{W{sgn & op.c[W-1]}}, op.c};
  assign m1 = ea * ec;
  assign m2 = eb * ec;

  generate
    if (LAT >= 3) begin : g_mid
      logic [LAT-2:1][2*W-1:0] d1, d2;
      always_ff @(posedge clk) begin
        if (adv) begin
          d1[1] <= m1;
          d2[1] <= m2;
          for (int i = 2; i <= LAT-2; i++) begin
            d1[i] <= d1[i-1];
            d2[i] <= d2[i-1];
          end
        end
      end
      assign f1 = d1[LAT-2];
      assign f2 = d2[LAT-2];
    end else begin : g_nomid
      assign f1 = m1;
      assign f2 = m2;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      p1 <= '0;
      p2 <= '0;
    end else if (adv) begin
`ifdef MUL_DUAL_ACC_EN
      if (upd) begin
        p1 <= accf ? p1 + f1 : f1;
        p2 <= accf ? p2 + f2 : f2;
      end
`else
      p1 <= f1;
      p2 <= f2;
`endif
    end
  end
endmodule

module mul_dual_array #(
  parameter int N   = 36,
  parameter int W   = 8,
  parameter int LAT = 3
) (
  input logic             clk,
  input logic             rst,
  mul_dual_array_if.slave bus
);
  localparam int S = LAT - 1;

  logic                      adv;
  logic                      fire;
  logic                      mul_sgn;
  logic [S:0]                vld_pipe;
  logic [N-1:0][W-1:0]       a_l, b_l, c_l;
  logic [N-1:0][2*W-1:0]     p1_l, p2_l;
`ifdef MUL_DUAL_ACC_EN
  logic                      upd;
  logic                      acc_fl;
`endif

  // Whole pipe moves as one; bubbles shift like beats.
  assign adv           = !vld_pipe[S] || bus.out_ready;
  assign bus.in_ready  = adv && !rst;
  assign fire          = bus.in_valid && bus.in_ready;
  assign bus.out_valid = vld_pipe[S];

  assign a_l      = bus.in_1;
  assign b_l      = bus.in_2;
  assign c_l      = bus.in_3;
  assign bus.out1 = p1_l;
  assign bus.out2 = p2_l;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
    end else if (adv) begin
      vld_pipe[0] <= fire;
      for (int i = 1; i <= S; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  generate
    if (LAT == 1) begin : g_lat1
      assign mul_sgn = bus.in_signed;
`ifdef MUL_DUAL_ACC_EN
      assign upd    = fire;
      assign acc_fl = bus.in_acc;
`endif
    end else begin : g_latn
      logic sgn_q;
      always_ff @(posedge clk) begin
        if (adv) sgn_q <= bus.in_signed;
      end
      assign mul_sgn = sgn_q;
`ifdef MUL_DUAL_ACC_EN
      // Accumulate flag rides alongside the beat until it enters the output stage.
      logic [S-1:0] acc_pipe;
      always_ff @(posedge clk) begin
        if (adv) begin
          acc_pipe[0] <= bus.in_acc;
          for (int i = 1; i < S; i++) acc_pipe[i] <= acc_pipe[i-1];
        end
      end
      assign upd    = vld_pipe[S-1];
      assign acc_fl = acc_pipe[S-1];
`endif
    end
  endgenerate

  generate
    for (genvar i = 0; i < N; i++) begin : g_lane
      mul_dual_lane #(.W(W), .LAT(LAT)) u_lane (
        .clk  (clk),
        .rst  (rst),
        .adv  (adv),
        .sgn  (mul_sgn),
`ifdef MUL_DUAL_ACC_EN
        .upd  (upd),
        .accf (acc_fl),
`endif
        .a    (a_l[i]),
        .b    (b_l[i]),
        .c    (c_l[i]),
        .p1   (p1_l[i]),
        .p2   (p2_l[i])
      );
    end
  endgenerate
endmodule

// File: tb/tb_mul_dual_array.sv
// Directed bench for mul_dual_array: N=4, W=8, LAT=3.
module tb_mul_dual_array;
  localparam int N = 4, W = 8, LAT = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mul_dual_array_if #(.N(N), .W(W)) bus ();
  mul_dual_array #(.N(N), .W(W), .LAT(LAT)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0, passed = 0, fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                       input logic s, input logic acc);
    bus.in_valid  = 1'b1;
    bus.in_1      = a;
    bus.in_2      = b;
    bus.in_3      = c;
    bus.in_signed = s;
`ifdef MUL_DUAL_ACC_EN
    bus.in_acc    = acc;
`else
    if (acc) bus.in_signed = s;
`endif
  endtask

  logic [31:0] bi1 [10], bi2 [10], bi3 [10];
  logic [63:0] ex1 [10], ex2 [10];
  logic [63:0] held1, held2;
  logic [15:0] accexp [5];
  logic        seen;
  int          sent, got;

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_signed = 1'b0; bus.out_ready = 1'b1;
    bus.in_1 = '0; bus.in_2 = '0; bus.in_3 = '0;
`ifdef MUL_DUAL_ACC_EN
    bus.in_acc = 1'b0;
`endif
    step(); step();
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out1", bus.out1, 64'd0);
    chk("rst_out2", bus.out2, 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

    // 1: unsigned single beat, latency
    drive(32'h0000_00FF, 32'h0000_0002, 32'h0000_00FF, 1'b0, 1'b0);
    step();
    bus.in_valid = 1'b0;
    chk("t1_lat_c1", 64'(bus.out_valid), 64'd0);
    step();
    chk("t1_lat_c2", 64'(bus.out_valid), 64'd0);
    step();
    chk("t1_valid", 64'(bus.out_valid), 64'd1);
    chk("t1_out1", bus.out1, 64'h0000_0000_0000_FE01);
    chk("t1_out2", bus.out2, 64'h0000_0000_0000_01FE);
    step();
    chk("t1_drop", 64'(bus.out_valid), 64'd0);

    // 2: signed then unsigned, lane3 = -128*-128
    drive(32'h8080_0000, 32'h807F_0000, 32'h80FF_0000, 1'b1, 1'b0);
    step();
    drive(32'h8080_0000, 32'h807F_0000, 32'h80FF_0000, 1'b0, 1'b0);
    step();
    bus.in_valid = 1'b0;
    chk("t2_early", 64'(bus.out_valid), 64'd0);
    step();
    chk("t2_s_valid", 64'(bus.out_valid), 64'd1);
    chk("t2_s_out1", bus.out1, 64'h4000_0080_0000_0000);
    chk("t2_s_out2", bus.out2, 64'h4000_FF81_0000_0000);
    step();
    chk("t2_u_valid", 64'(bus.out_valid), 64'd1);
    chk("t2_u_out1", bus.out1, 64'h4000_7F80_0000_0000);
    chk("t2_u_out2", bus.out2, 64'h4000_7E81_0000_0000);
    step();
    chk("t2_drop", 64'(bus.out_valid), 64'd0);

    // 4: lane isolation, signed by -128
    drive(32'h0403_0201, 32'h0705_0301, 32'h8080_8080, 1'b1, 1'b0);
    step();
    bus.in_valid = 1'b0;
    step(); step();
    chk("t4_valid", 64'(bus.out_valid), 64'd1);
    chk("t4_out1", bus.out1, 64'hFE00_FE80_FF00_FF80);
    chk("t4_out2", bus.out2, 64'hFC80_FD80_FE80_FF80);
    step();

    // 3: back-pressure stream of 10 beats, stall cycles 5..7
    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j < N; j++) begin
        bi1[k][8*j +: 8] = 8'(k*4 + j + 1);
        bi2[k][8*j +: 8] = 8'(200 - k*4 - j);
        bi3[k][8*j +: 8] = 8'(j + 2 + k);
        ex1[k][16*j +: 16] = 16'(bi1[k][8*j +: 8]) * 16'(bi3[k][8*j +: 8]);
        ex2[k][16*j +: 16] = 16'(bi2[k][8*j +: 8]) * 16'(bi3[k][8*j +: 8]);
      end
    end
    sent = 0; got = 0; held1 = '0; held2 = '0;
    for (int c = 0; c < 40 && got < 10; c++) begin
      bus.out_ready = !(c >= 5 && c <= 7);
      if (sent < 10) drive(bi1[sent], bi2[sent], bi3[sent], 1'b0, 1'b0);
      else bus.in_valid = 1'b0;
      #1;
      if (sent < 10) chk("bp_in_ready", 64'(bus.in_ready), (c >= 5 && c <= 7) ? 64'd0 : 64'd1);
      if (c == 5) begin held1 = bus.out1; held2 = bus.out2; end
      if (c >= 5 && c <= 7) chk("bp_stall_valid", 64'(bus.out_valid), 64'd1);
      if (c == 6 || c == 7) begin
        chk("bp_hold_out1", bus.out1, held1);
        chk("bp_hold_out2", bus.out2, held2);
      end
      if (bus.out_valid && bus.out_ready) begin
        chk("bp_out1", bus.out1, ex1[got]);
        chk("bp_out2", bus.out2, ex2[got]);
        got++;
      end
      if (bus.in_valid && bus.in_ready) sent++;
      step();
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    chk("bp_sent", 64'(sent), 64'd10);
    chk("bp_got", 64'(got), 64'd10);
    step();
    chk("bp_no_dup", 64'(bus.out_valid), 64'd0);

    // 5: reset with two beats in flight
    drive(32'h0000_0011, 32'h0000_0001, 32'h0000_0003, 1'b0, 1'b0);
    step();
    drive(32'h0000_0022, 32'h0000_0005, 32'h0000_0004, 1'b0, 1'b0);
    step();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("t5_in_ready_rst", 64'(bus.in_ready), 64'd0);
    step();
    chk("t5_valid", 64'(bus.out_valid), 64'd0);
    chk("t5_out1", bus.out1, 64'd0);
    chk("t5_out2", bus.out2, 64'd0);
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      seen = seen | bus.out_valid;
      step();
    end
    chk("t5_discarded", 64'(seen), 64'd0);
    drive(32'h0000_1000, 32'h0000_0200, 32'h0000_1000, 1'b0, 1'b0);
    step();
    bus.in_valid = 1'b0;
    chk("t5_new_c1", 64'(bus.out_valid), 64'd0);
    step();
    chk("t5_new_c2", 64'(bus.out_valid), 64'd0);
    step();
    chk("t5_new_valid", 64'(bus.out_valid), 64'd1);
    chk("t5_new_out1", bus.out1, 64'h0000_0000_0100_0000);
    chk("t5_new_out2", bus.out2, 64'h0000_0000_0020_0000);
    step();

`ifdef MUL_DUAL_ACC_EN
    // 6: accumulate on lane0, wrapping at 16 bits
    accexp[0] = 16'h000C; accexp[1] = 16'h002A; accexp[2] = 16'h002E;
    accexp[3] = 16'hFE2F; accexp[4] = 16'hFC30;
    bi1[0] = 32'h03; bi1[1] = 32'h05; bi1[2] = 32'h02; bi1[3] = 32'hFF; bi1[4] = 32'hFF;
    bi3[0] = 32'h04; bi3[1] = 32'h06; bi3[2] = 32'h02; bi3[3] = 32'hFF; bi3[4] = 32'hFF;
    for (int c = 0; c < 7; c++) begin
      if (c < 5) drive(bi1[c], 32'h0, bi3[c], 1'b0, c != 0);
      else bus.in_valid = 1'b0;
      step();
      if (c >= 2) begin
        chk("acc_valid", 64'(bus.out_valid), 64'd1);
        chk("acc_out1", bus.out1, {48'h0, accexp[c-2]});
      end
    end
    bus.in_valid = 1'b0;
`else
    accexp[0] = 16'h0; seen = 1'b0;
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mul_dual_array.md
Name: mul_dual_array

Overview:
Parametrised, pipelined array of N multiplier lanes. Each lane forms two products that share one operand: out1 = in_1*in_3 and out2 = in_2*in_3.
- Widths, lane count and latency are generic.
- Signed or unsigned mode is selected per beat.
- A valid/ready elastic handshake on both sides supports back-pressure.
- Sits between the operand fetch/broadcast logic and the accumulation stage of the MAC core.

Parameters:
N, 36, number of lanes
W, 8, operand width per lane (>=2)
LAT, 3, pipeline stages from accepted beat to output (>=1)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  input beat valid
in_ready  output  1  block can accept a beat this cycle
in_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with the beat
in_1  input  W*N  operand A, lane i at bits [W*i+W-1 : W*i]
in_2  input  W*N  operand B, same packing
in_3  input  W*N  shared operand C, same packing
out_valid  output  1  output beat valid
out_ready  input  1  downstream accepts the output beat
out1  output  2W*N  lane i product A*C at bits [2W*i+2W-1 : 2W*i]
out2  output  2W*N  lane i product B*C, same packing

Behaviour:
- Beat accepted when in_valid && in_ready at a rising edge. Output beat consumed when out_valid && out_ready.
- Global advance: adv = !out_valid || out_ready. The whole pipeline shifts only when adv=1.
- in_ready = adv && !rst. It is combinational from out_valid/out_ready; there is no path from in_valid to in_ready.
- Each of the LAT stages carries a valid bit plus data and the signed flag. Bubbles are not collapsed: an invalid stage shifts like a valid one.
- Latency: with no stall, out_valid rises exactly LAT cycles after the accepting edge. Throughput is 1 beat/cycle.
- Stall: while out_valid=1 and out_ready=0, out_valid, out1 and out2 hold stable, and no stage changes.
- Arithmetic: each product is exact, full 2W bits, with no truncation or rounding.
  - Signed mode: operands are sign-extended and the result is the 2W-bit two's complement product.
  - Unsigned mode: operands are zero-extended.
  - -2^(W-1) * -2^(W-1) = 2^(2W-2), which fits in 2W bits as a positive value.
- Lanes are fully independent; there is no carry or sign leakage between adjacent lanes.
- Beats leave in acceptance order; no beat is lost or duplicated.
- Reset, including mid-operation:
  - At the next edge, all stage valid bits clear, out_valid=0, out1=0 and out2=0.
  - All in-flight beats are discarded and never emerge.
  - in_ready=0 while rst=1.
  - Internal data registers need no reset.
- Simultaneous output consume and input accept in the same cycle is legal and sustains full rate.

Optional Feature:
MUL_DUAL_ACC_EN
- Defined:
  - Adds port in_acc (input, 1 bit), sampled with the beat.
  - Each lane holds two 2W-bit accumulators, updated when a beat reaches the output stage.
  - in_acc=0: accumulator loads the product.
  - in_acc=1: accumulator loads accumulator + product, wrapping modulo 2^(2W).
  - out1/out2 present the accumulator values; latency is unchanged.
  - Accumulators update only on output-stage advance, never during a stall.
  - rst clears the accumulators to 0.
- Undefined: in_acc is absent and out1/out2 are pure products.

Test Plan:
1. Unsigned, N=4, W=8, LAT=3: lane0 in_1=0xFF, in_2=0x02, in_3=0xFF, in_signed=0, single beat -> exactly 3 cycles later out_valid=1, lane0 out1=0xFE01, out2=0x01FE; out_valid deasserts after one cycle with out_ready=1.
2. Signed: lane2 in_1=0x80, in_2=0x7F, in_3=0xFF, in_signed=1 -> out1=0x0080, out2=0xFF81. Same operands with in_signed=0 in the next beat -> out1=0x7F80, out2=0x7E81.
3. Back-pressure: stream 10 beats back-to-back, out_ready=0 for 3 cycles mid-stream -> in_ready low in exactly those cycles, outputs held stable, all 10 results emerge in order, no loss or duplication.
4. Lane isolation: lane i gets in_1=i+1, in_2=2i+1, in_3=0x80 (signed) -> every lane matches its own signed products, and the adjacent-lane fields are unaffected.
5. Reset mid-operation: accept 2 beats, assert rst 1 cycle before either emerges -> out_valid=0, out1=out2=0 the next cycle, neither beat ever appears, and the next accepted beat has normal LAT latency.
6. MUL_DUAL_ACC_EN: lane0 beats (in_1=3, in_3=4, acc=0), (5, 6, acc=1), (2, 2, acc=1) -> out1 sequence 12, 42, 46. Then (0xFF, 0xFF, acc=1) repeated twice, unsigned -> out1 0xFE2F, then 0xFC30 (wrapped).
